// File: rtl/dmem_waitstate.sv
// Data memory with a valid/ready request port, WAIT_CYCLES programmable wait states and a
// one-cycle response strobe. Define DMEM_RESET_CLEAR_EN to clear the array on RST.
module dmem_waitstate #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Req_Valid,
  input  logic              Req_Write,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [DATA_W-1:0] Req_WD,
  output logic              Req_Ready,
  output logic              Resp_Valid,
  output logic [DATA_W-1:0] RD,
  output logic              Err
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wd_q;
  logic              resp_q;
  logic              err_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              acc_go;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [DATA_W-1:0] acc_wd;
  logic              acc_in;
  logic [IDX_W-1:0]  acc_idx;
  logic              mem_wr;

  // With no wait states the access happens on the accept edge, straight from the port.
  always_comb begin
    acc_go   = 1'b0;
    acc_addr = addr_q;
    acc_we   = we_q;
    acc_wd   = wd_q;
    if (WAIT_CYCLES == 0) begin
      if ((state_q == ST_IDLE) && Req_Valid) begin
        acc_go   = 1'b1;
        acc_addr = Req_Addr;
        acc_we   = Req_Write;
        acc_wd   = Req_WD;
      end else begin
        acc_go   = 1'b0;
      end
    end else begin
      if ((state_q == ST_WAIT) && (cnt_q == 4'd0)) begin
        acc_go = 1'b1;
      end else begin
        acc_go = 1'b0;
      end
    end
    acc_in  = ({1'b0, acc_addr} < DEPTH_L);
    acc_idx = acc_addr[IDX_W-1:0];
    mem_wr  = acc_go & acc_we & acc_in;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          resp_q <= 1'b0;
          err_q  <= 1'b0;
          if (Req_Valid) begin
            addr_q <= Req_Addr;
            we_q   <= Req_Write;
            wd_q   <= Req_WD;
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_DONE;
              cnt_q   <= 4'd0;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          resp_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          resp_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
      // Completion overrides the per-state defaults above; reads out of range return zero.
      if (acc_go) begin
        resp_q <= 1'b1;
        err_q  <= ~acc_in;
        if (!acc_we) begin
          rd_q <= acc_in ? mem_q[acc_idx] : '0;
        end
      end
    end
  end

`ifdef DMEM_RESET_CLEAR_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_wr) begin
      mem_q[acc_idx] <= acc_wd;
    end
  end
`else
  // No reset on the array so it can map onto block RAM.
  always_ff @(posedge CLK) begin
    if (mem_wr) begin
      mem_q[acc_idx] <= acc_wd;
    end
  end
`endif

  assign Req_Ready  = (state_q == ST_IDLE);
  assign Resp_Valid = resp_q;
  assign RD         = rd_q;
  assign Err        = err_q;

endmodule
